// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the default operand width, FSM state encoding and divide-by-zero quotient.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Quotient reported for divide by zero at the default width.
    localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/div_ctrl.sv
// Divider sequencer: FSM, iteration counter, ready/valid and datapath strobes.
// Latency: WIDTH shift cycles plus one write cycle; divide by zero writes on the next edge.
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic div_zero_i,
    output logic ready_o,
    output logic valid_o,
    output logic load_o,
    output logic shift_o,
    output logic write_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        load_o  = 1'b0;
        shift_o = 1'b0;
        write_o = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    load_o  = 1'b1;
                    state_d = RUN;
                    // A zero divisor jumps the counter to its terminal value so the
                    // result is written on the very next edge without iterating.
                    cnt_d   = div_zero_i ? CNT_W'(WIDTH) : '0;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(WIDTH)) begin
                    write_o = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    shift_o = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            DONE: begin
                valid_o = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock; result valid pulses one cycle.
// Optional signed mode via DIVIDER_SEQ_SIGNED_EN; start is ignored whenever ready is low.
module divider_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             valid,
    output logic             dz,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic load, shift, write;
    logic div_zero;

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             dzp_q, dzp_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dz_q, dz_d;
    logic [WIDTH+1:0] trial;
    logic             trial_ok;

`ifdef DIVIDER_SEQ_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
`endif

    assign div_zero = (divisor == '0);

    div_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .div_zero_i (div_zero),
        .ready_o    (ready),
        .valid_o    (valid),
        .load_o     (load),
        .shift_o    (shift),
        .write_o    (write)
    );

    // Shifted partial remainder minus divisor; two extra bits keep the borrow honest
    // when the shifted value exceeds WIDTH bits.
    assign trial    = {1'b0, rem_q, quo_q[WIDTH-1]} - {2'b00, dvs_q};
    assign trial_ok = ~|trial[WIDTH+1:WIDTH];

    always_comb begin
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        dzp_d       = dzp_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;
`ifdef DIVIDER_SEQ_SIGNED_EN
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
`endif
        if (load) begin
            rem_d = '0;
            dzp_d = div_zero;
`ifdef DIVIDER_SEQ_SIGNED_EN
            // Divide by zero keeps the raw dividend so it can be returned as-is.
            quo_d  = (dividend[WIDTH-1] && !div_zero) ? (~dividend + 1'b1) : dividend;
            dvs_d  = divisor[WIDTH-1] ? (~divisor + 1'b1) : divisor;
            qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_d = dividend[WIDTH-1];
`else
            quo_d  = dividend;
            dvs_d  = divisor;
`endif
        end else if (shift) begin
            if (trial_ok) begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end else if (write) begin
            if (dzp_q) begin
                quotient_d  = '1;
                remainder_d = quo_q;
                dz_d        = 1'b1;
            end else begin
`ifdef DIVIDER_SEQ_SIGNED_EN
                quotient_d  = qneg_q ? (~quo_q + 1'b1) : quo_q;
                remainder_d = rneg_q ? (~rem_q + 1'b1) : rem_q;
`else
                quotient_d  = quo_q;
                remainder_d = rem_q;
`endif
                dz_d        = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            dzp_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
`ifdef DIVIDER_SEQ_SIGNED_EN
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
`endif
        end else begin
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            dzp_q       <= dzp_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
`ifdef DIVIDER_SEQ_SIGNED_EN
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
`endif
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Directed bench for divider_seq; latency is counted in clock edges after the accepting edge.
module tb_divider_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        ready;
    logic        valid;
    logic        dz;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int total = 0;
    int bad   = 0;

    divider_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .valid     (valid),
        .dz        (dz),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    // Presents a request for one cycle; returns at the negedge after the accepting edge.
    task automatic kick(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom;
    endtask

    // Bounded wait for valid; a timeout returns 100, which no latency check accepts.
    task automatic wait_valid(input int from, output int lat);
        lat = from;
        while (!valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        total++; if ({dz, quotient, remainder} !== 65'd0) begin bad++;
            $display("FAIL reset_outputs: got dz=%b q=%h r=%h want zeros", dz, quotient, remainder); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat;
        kick(32'd100, 32'd7);
        wait_valid(0, lat);
        total++; if (lat !== 33) begin bad++; $display("FAIL basic_latency: got %0d want 33", lat); end
        total++; if (quotient !== 32'h0000000E) begin bad++; $display("FAIL basic_q: got %h want 0000000e", quotient); end
        total++; if (remainder !== 32'h00000002) begin bad++; $display("FAIL basic_r: got %h want 00000002", remainder); end
        total++; if (dz !== 1'b0) begin bad++; $display("FAIL basic_dz: got %b want 0", dz); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL basic_ready_in_valid: got %b want 0", ready); end
        @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL basic_valid_pulse: got %b want 0", valid); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back: got %b want 1", ready); end
        repeat (3) @(negedge clk);
        total++; if (quotient !== 32'h0000000E) begin bad++; $display("FAIL basic_persist: got %h want 0000000e", quotient); end
    endtask

    task automatic test_max;
        int lat;
        kick(32'hFFFFFFFF, 32'h1);
        wait_valid(0, lat);
        total++; if (quotient !== 32'hFFFFFFFF) begin bad++; $display("FAIL max_q: got %h want ffffffff", quotient); end
        total++; if (remainder !== 32'h0) begin bad++; $display("FAIL max_r: got %h want 00000000", remainder); end
        @(negedge clk);
        kick(32'd3, 32'hFFFFFFFF);
        wait_valid(0, lat);
        total++; if (quotient !== 32'h0) begin bad++; $display("FAIL small_q: got %h want 00000000", quotient); end
        total++; if (remainder !== 32'd3) begin bad++; $display("FAIL small_r: got %h want 00000003", remainder); end
        @(negedge clk);
    endtask

    task automatic test_div_zero;
        int lat;
        kick(32'h12345678, 32'h0);
        wait_valid(0, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL dz_latency: got %0d want 1", lat); end
        total++; if (quotient !== 32'hFFFFFFFF) begin bad++; $display("FAIL dz_q: got %h want ffffffff", quotient); end
        total++; if (remainder !== 32'h12345678) begin bad++; $display("FAIL dz_r: got %h want 12345678", remainder); end
        total++; if (dz !== 1'b1) begin bad++; $display("FAIL dz_flag: got %b want 1", dz); end
        @(negedge clk);
        kick(32'd9, 32'd3);
        wait_valid(0, lat);
        total++; if (dz !== 1'b0) begin bad++; $display("FAIL dz_clear: got %b want 0", dz); end
        total++; if (quotient !== 32'd3) begin bad++; $display("FAIL dz_after_q: got %h want 00000003", quotient); end
        @(negedge clk);
    endtask

    task automatic test_busy;
        int lat;
        int extra;
        kick(32'd50, 32'd5);
        repeat (8) @(negedge clk);
        start = 1'b1; dividend = 32'd8; divisor = 32'd2;
        @(negedge clk);
        start = 1'b0;
        wait_valid(9, lat);
        total++; if (lat !== 33) begin bad++; $display("FAIL busy_latency: got %0d want 33", lat); end
        total++; if (quotient !== 32'd10) begin bad++; $display("FAIL busy_q: got %h want 0000000a", quotient); end
        total++; if (remainder !== 32'd0) begin bad++; $display("FAIL busy_r: got %h want 00000000", remainder); end
        @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL busy_ready_back: got %b want 1", ready); end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL busy_no_second: got %0d valids want 0", extra); end
    endtask

    task automatic test_reset_mid;
        int lat;
        kick(32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if ({dz, quotient, remainder} !== 65'd0) begin bad++;
            $display("FAIL midrst_outputs: got dz=%b q=%h r=%h want zeros", dz, quotient, remainder); end
        total++; if (ready !== 1'b1 || valid !== 1'b0) begin bad++;
            $display("FAIL midrst_handshake: got ready=%b valid=%b want 1/0", ready, valid); end
        @(negedge clk);
        rst = 1'b0;
        kick(32'd1000, 32'd3);
        wait_valid(0, lat);
        total++; if (lat !== 33) begin bad++; $display("FAIL midrst_latency: got %0d want 33", lat); end
        total++; if (quotient !== 32'd333) begin bad++; $display("FAIL midrst_q: got %0d want 333", quotient); end
        total++; if (remainder !== 32'd1) begin bad++; $display("FAIL midrst_r: got %0d want 1", remainder); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        start = 1'b1; dividend = 32'd20; divisor = 32'd4;
        @(negedge clk);
        wait_valid(0, lat);
        total++; if (lat !== 33 || quotient !== 32'd5) begin bad++;
            $display("FAIL b2b_first: got lat=%0d q=%0d want 33/5", lat, quotient); end
        dividend = 32'd21;
        @(negedge clk);
        // Valid cycle, then one IDLE cycle that accepts, then 33 more edges.
        wait_valid(34, lat);
        start = 1'b0;
        total++; if (lat !== 68) begin bad++; $display("FAIL b2b_latency: got %0d want 68", lat); end
        total++; if (quotient !== 32'd5 || remainder !== 32'd1) begin bad++;
            $display("FAIL b2b_second: got q=%0d r=%0d want 5/1", quotient, remainder); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sign_mode;
        int lat;
`ifdef DIVIDER_SEQ_SIGNED_EN
        kick(32'hFFFFFFF9, 32'd2);
        wait_valid(0, lat);
        total++; if (quotient !== 32'hFFFFFFFD || remainder !== 32'hFFFFFFFF) begin bad++;
            $display("FAIL signed_neg7_2: got q=%h r=%h want fffffffd/ffffffff", quotient, remainder); end
        @(negedge clk);
        kick(32'h80000000, 32'hFFFFFFFF);
        wait_valid(0, lat);
        total++; if (quotient !== 32'h80000000 || remainder !== 32'h0 || dz !== 1'b0) begin bad++;
            $display("FAIL signed_minneg: got q=%h r=%h dz=%b want 80000000/0/0", quotient, remainder, dz); end
        @(negedge clk);
        kick(32'd7, 32'hFFFFFFFE);
        wait_valid(0, lat);
        total++; if (quotient !== 32'hFFFFFFFD || remainder !== 32'd1) begin bad++;
            $display("FAIL signed_7_neg2: got q=%h r=%h want fffffffd/00000001", quotient, remainder); end
`else
        kick(32'hFFFFFFF9, 32'd2);
        wait_valid(0, lat);
        total++; if (quotient !== 32'h7FFFFFFC || remainder !== 32'd1) begin bad++;
            $display("FAIL unsigned_big_2: got q=%h r=%h want 7ffffffc/00000001", quotient, remainder); end
        @(negedge clk);
        kick(32'h80000000, 32'hFFFFFFFF);
        wait_valid(0, lat);
        total++; if (quotient !== 32'h0 || remainder !== 32'h80000000) begin bad++;
            $display("FAIL unsigned_msb: got q=%h r=%h want 00000000/80000000", quotient, remainder); end
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_div_zero();
        test_busy();
        test_reset_mid();
        test_back_to_back();
        test_sign_mode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
